// File: rtl/conv_output_collector.sv
// Output stage after the convolution: drops pipeline-fill and row-wrap beats, tags kept pixels
// with end-of-line/end-of-frame, and buffers them in a FIFO. Optional: CONV_COLLECT_CHECKSUM_EN.
module conv_output_collector #(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int COL_SIZE     = 540,
  parameter int KERNEL_DIM   = 3,
  parameter int PIPE_LATENCY = 1086,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inValid,
  output logic [WORD_SIZE-1:0] outPixel,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outLast,
  output logic                 outFrameEnd,
  output logic                 overflow,
  output logic                 frameDone
`ifdef CONV_COLLECT_CHECKSUM_EN
  ,
  output logic [15:0]          frameChecksum
`endif
);

  localparam int SKW = $clog2(PIPE_LATENCY + 1);
  localparam int CW  = $clog2(ROW_SIZE);
  localparam int RW  = $clog2(COL_SIZE);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = WORD_SIZE + 2;

  localparam logic [SKW-1:0] SKIP_END = SKW'(PIPE_LATENCY - 1);
  localparam logic [CW-1:0]  LAST_COL = CW'(ROW_SIZE - KERNEL_DIM);
  localparam logic [CW-1:0]  END_COL  = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(COL_SIZE - KERNEL_DIM);
  localparam logic [NW-1:0]  FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {SKIP, COLLECT, DONE} state_t;

  state_t          state;
  logic [SKW-1:0]  skip_cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;

  logic keep, is_last, is_fend, push, pop, full, accept;
  logic [EW-1:0] head;

  always_comb begin
    keep    = (col <= LAST_COL);
    is_last = (col == LAST_COL);
    is_fend = is_last && (row == LAST_ROW);
    push    = (state == COLLECT) && inValid && keep;
    full    = (count == FULL_CNT);
    pop     = (count != '0) && outReady;
    // A pop in the same cycle frees the slot the push needs.
    accept  = push && (!full || pop);
    head    = mem[rd_ptr];
  end

  assign outValid    = (count != '0);
  assign outPixel    = head[WORD_SIZE-1:0];
  assign outLast     = head[WORD_SIZE];
  assign outFrameEnd = head[WORD_SIZE+1];
  assign frameDone   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SKIP;
      skip_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      case (state)
        SKIP: if (inValid) begin
          if (skip_cnt == SKIP_END) state <= COLLECT;
          else                      skip_cnt <= skip_cnt + SKW'(1);
        end
        COLLECT: if (inValid) begin
          if (is_fend) state <= DONE;
          if (col == END_COL) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        DONE: ;
        default: state <= SKIP;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads 0 after a mid-frame reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {is_fend, is_last, inputPixel};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !accept) overflow <= 1'b1;
      count <= count + NW'(accept) - NW'(pop);
    end
  end

`ifdef CONV_COLLECT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)         frameChecksum <= '0;
    else if (accept) frameChecksum <= frameChecksum + 16'(inputPixel);
  end
`endif

endmodule

// File: tb/tb_conv_output_collector.sv
// Bench for conv_output_collector on an 8x6 frame; a queue model of the FIFO predicts every output.
module tb_conv_output_collector;
  localparam int W = 8, R = 8, C = 6, K = 3, PL = 4, FD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] inputPixel = '0;
  logic         inValid = 1'b0;
  logic [W-1:0] outPixel;
  logic         outValid, outReady, outLast, outFrameEnd, overflow, frameDone;
`ifdef CONV_COLLECT_CHECKSUM_EN
  logic [15:0]  frameChecksum;
`endif

  always #5 clk = ~clk;

  conv_output_collector #(
    .WORD_SIZE(W), .ROW_SIZE(R), .COL_SIZE(C), .KERNEL_DIM(K),
    .PIPE_LATENCY(PL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .inputPixel(inputPixel), .inValid(inValid),
    .outPixel(outPixel), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .outFrameEnd(outFrameEnd), .overflow(overflow),
    .frameDone(frameDone)
`ifdef CONV_COLLECT_CHECKSUM_EN
    , .frameChecksum(frameChecksum)
`endif
  );

  typedef struct packed { logic fe; logic last; logic [W-1:0] pix; } ent_t;

  ent_t q[$];
  int   total = 0, bad = 0;
  int   nb, npop;
  logic exp_ovf, exp_done;

  task automatic model_clear();
    q.delete();
    nb = 0; npop = 0; exp_ovf = 1'b0; exp_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inValid = 1'b0; inputPixel = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step(input logic v, input logic [W-1:0] p);
    int pos, col, row;
    ent_t e;
    inValid = v; inputPixel = p;
    total++;
    if (outValid !== (q.size() > 0)) begin
      bad++; $display("FAIL outValid got=%b exp=%b beat=%0d", outValid, q.size() > 0, nb);
    end
    if (q.size() > 0) begin
      total++;
      if ({outFrameEnd, outLast, outPixel} !== q[0]) begin
        bad++; $display("FAIL head got fe=%b last=%b pix=%h exp fe=%b last=%b pix=%h",
                        outFrameEnd, outLast, outPixel, q[0].fe, q[0].last, q[0].pix);
      end
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL overflow got=%b exp=%b beat=%0d", overflow, exp_ovf, nb);
    end
    total++;
    if (frameDone !== exp_done) begin
      bad++; $display("FAIL frameDone got=%b exp=%b beat=%0d", frameDone, exp_done, nb);
    end
    if (q.size() > 0 && outReady) begin
      void'(q.pop_front());
      npop++;
    end
    if (v && !exp_done) begin
      if (nb >= PL) begin
        pos = nb - PL; col = pos % R; row = pos / R;
        if (col <= R - K) begin
          e.pix  = p;
          e.last = (col == R - K);
          e.fe   = e.last && (row == C - K);
          if (q.size() < FD) q.push_back(e);
          else exp_ovf = 1'b1;
          if (e.fe) exp_done = 1'b1;
        end
      end
      nb++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic test_reset();
    outReady = 1'b0;
    do_reset();
    total++; if (outValid !== 1'b0)    begin bad++; $display("FAIL rst_outValid got=%b exp=0", outValid); end
    total++; if (outPixel !== '0)      begin bad++; $display("FAIL rst_outPixel got=%h exp=00", outPixel); end
    total++; if (outLast !== 1'b0)     begin bad++; $display("FAIL rst_outLast got=%b exp=0", outLast); end
    total++; if (outFrameEnd !== 1'b0) begin bad++; $display("FAIL rst_outFrameEnd got=%b exp=0", outFrameEnd); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (frameDone !== 1'b0)   begin bad++; $display("FAIL rst_frameDone got=%b exp=0", frameDone); end
`ifdef CONV_COLLECT_CHECKSUM_EN
    total++; if (frameChecksum !== 16'h0) begin bad++; $display("FAIL rst_checksum got=%h exp=0000", frameChecksum); end
`endif
  endtask

  task automatic test_fill_skip();
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, W'(i));
    step(1'b1, 8'h10);
    total++;
    if (outValid !== 1'b1 || outPixel !== 8'h10) begin
      bad++; $display("FAIL first_pixel got v=%b pix=%h exp v=1 pix=10", outValid, outPixel);
    end
    drain(2);
  endtask

  task automatic test_full_frame();
    do_reset();
    outReady = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, W'(i));
    drain(6);
    total++; if (npop !== 24) begin bad++; $display("FAIL frame_count got=%0d exp=24", npop); end
    total++; if (frameDone !== 1'b1) begin bad++; $display("FAIL frame_done got=%b exp=1", frameDone); end
  endtask

  task automatic test_stall();
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b1, W'(i));
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL stall_overflow got=%b exp=1", overflow); end
    outReady = 1'b1;
    for (int i = 14; i < 40; i++) step(1'b1, W'(i));
    drain(6);
    total++; if (npop !== 20) begin bad++; $display("FAIL stall_count got=%0d exp=20", npop); end
  endtask

  task automatic test_full_simul();
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, W'(i));
    outReady = 1'b1;
    for (int i = 8; i < 12; i++) step(1'b1, W'(i));
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
    drain(6);
    total++; if (npop !== 6) begin bad++; $display("FAIL simul_count got=%0d exp=6", npop); end
  endtask

  task automatic test_gaps();
    do_reset();
    outReady = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) step(1'b1, W'(i / 2));
      else            step(1'b0, 8'hAA);
    end
    drain(6);
    total++; if (npop !== 24) begin bad++; $display("FAIL gaps_count got=%0d exp=24", npop); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    outReady = 1'b1;
    for (int i = 0; i < 40 && npop < 10; i++) step(1'b1, W'(i));
    rst = 1'b1; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL mid_outValid got=%b exp=0", outValid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    model_clear();
    for (int i = 0; i < 40; i++) step(1'b1, W'(i));
    drain(6);
    total++; if (npop !== 24) begin bad++; $display("FAIL mid_count got=%0d exp=24", npop); end
  endtask

`ifdef CONV_COLLECT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    outReady = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, 8'hFF);
    total++;
    if (frameChecksum !== 16'h17E8) begin
      bad++; $display("FAIL checksum got=%h exp=17e8", frameChecksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_skip();
    test_full_frame();
    test_stall();
    test_full_simul();
    test_gaps();
    test_reset_mid();
`ifdef CONV_COLLECT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
